// File: rtl/ibex_dmem_adapter.sv
// LSU-to-SRAM data port adapter with bounded outstanding requests.
// Ports: clk_i/rst_ni; data_* LSU side; mem_* SRAM side; err_addr_o/err_clr_i.
// Optional range check: define IBEX_DMEM_RANGE_CHK_EN.
module ibex_dmem_adapter #(
  parameter int unsigned MemWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  input  logic [31:0]                 data_addr_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_wdata_i,
  output logic                        data_rvalid_o,
  output logic [31:0]                 data_rdata_o,
  output logic                        data_err_o,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic                        mem_we_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  output logic [31:0]                 mem_wmask_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic [31:0]                 err_addr_o,
  input  logic                        err_clr_i
);

  localparam int unsigned AW = $clog2(MemWords);
  localparam int unsigned L  = RespLatency;
  localparam logic [2:0]  MaxOut = 3'(MaxOutstanding);

  logic          in_range;
  logic          cap;
  logic          retire;
  logic          grant;
  logic [2:0]    cnt_q, cnt_d;
  logic [L-1:0]  vld_q, we_q, err_q;
  logic [31:0]   err_addr_q, err_addr_d;
  logic [31:0]   rdata_raw;

`ifdef IBEX_DMEM_RANGE_CHK_EN
  localparam logic [32:0] EndAddr =
    {1'b0, BaseAddr} + (33'(MemWords) << 2);
  assign in_range = ({1'b0, data_addr_i} >= {1'b0, BaseAddr}) &&
                    ({1'b0, data_addr_i} < EndAddr);
`else
  assign in_range = 1'b1;
`endif

  // A response retiring this cycle frees a slot for a same-cycle grant.
  assign retire = vld_q[L-1];
  assign cap    = (cnt_q < MaxOut) | retire;
  assign grant  = data_req_i & cap & (mem_gnt_i | ~in_range);

  assign data_gnt_o  = grant;
  assign mem_req_o   = data_req_i & in_range & cap;
  assign mem_we_o    = data_we_i;
  assign mem_addr_o  = data_addr_i[AW+1:2];
  assign mem_wdata_o = data_wdata_i;

  always_comb begin
    mem_wmask_o = '0;
    for (int i = 0; i < 4; i++) begin
      mem_wmask_o[8*i +: 8] = {8{data_be_i[i]}};
    end
  end

  always_comb begin
    cnt_d = cnt_q + {2'b00, grant} - {2'b00, retire};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      vld_q <= '0;
      we_q  <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = L - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        we_q[i]  <= we_q[i-1];
        err_q[i] <= err_q[i-1];
      end
      vld_q[0] <= grant;
      we_q[0]  <= grant & data_we_i;
      err_q[0] <= grant & ~in_range;
    end
  end

  generate
    if (L == 1) begin : g_direct
      assign rdata_raw = mem_rdata_i;
    end else begin : g_delay
      // SRAM data is only valid the cycle after grant, so it is
      // captured then and carried down to the response slot.
      logic [31:0] rd_q [L-1];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < L - 1; i++) begin
            rd_q[i] <= '0;
          end
        end else begin
          rd_q[0] <= vld_q[0] ? mem_rdata_i : 32'h0;
          for (int i = 1; i < L - 1; i++) begin
            rd_q[i] <= rd_q[i-1];
          end
        end
      end
      assign rdata_raw = rd_q[L-2];
    end
  endgenerate

  assign data_rvalid_o = vld_q[L-1];
  assign data_err_o    = vld_q[L-1] & err_q[L-1];
  assign data_rdata_o  =
    (vld_q[L-1] & ~we_q[L-1] & ~err_q[L-1]) ? rdata_raw : 32'h0;

  // A new error capture takes priority over a clear.
  always_comb begin
    err_addr_d = err_addr_q;
    if (grant & ~in_range) begin
      err_addr_d = data_addr_i;
    end else if (err_clr_i) begin
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_addr_q <= '0;
    end else begin
      err_addr_q <= err_addr_d;
    end
  end

  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_ibex_dmem_adapter.sv
// Directed bench for ibex_dmem_adapter: three latency configs.
// Table-driven single transactions plus multi-cycle sequences.
module tb_ibex_dmem_adapter;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        mgnt = 1'b0;
  logic [31:0] mrdata = '0;
  logic        clr = 1'b0;

  logic        a_gnt, a_rv, a_err, a_mreq, a_mwe;
  logic [31:0] a_rd, a_wm, a_wd, a_ea;
  logic [11:0] a_ma;
  logic        b_gnt, b_rv, b_err, b_mreq, b_mwe;
  logic [31:0] b_rd, b_wm, b_wd, b_ea;
  logic [11:0] b_ma;
  logic        c_gnt, c_rv, c_err, c_mreq, c_mwe;
  logic [31:0] c_rd, c_wm, c_wd, c_ea;
  logic [11:0] c_ma;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ibex_dmem_adapter u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req), .data_gnt_o(a_gnt),
    .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(a_rv), .data_rdata_o(a_rd),
    .data_err_o(a_err), .mem_req_o(a_mreq),
    .mem_gnt_i(mgnt), .mem_we_o(a_mwe),
    .mem_addr_o(a_ma), .mem_wmask_o(a_wm),
    .mem_wdata_o(a_wd), .mem_rdata_i(mrdata),
    .err_addr_o(a_ea), .err_clr_i(clr)
  );

  ibex_dmem_adapter #(.RespLatency(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req), .data_gnt_o(b_gnt),
    .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(b_rv), .data_rdata_o(b_rd),
    .data_err_o(b_err), .mem_req_o(b_mreq),
    .mem_gnt_i(mgnt), .mem_we_o(b_mwe),
    .mem_addr_o(b_ma), .mem_wmask_o(b_wm),
    .mem_wdata_o(b_wd), .mem_rdata_i(mrdata),
    .err_addr_o(b_ea), .err_clr_i(clr)
  );

  ibex_dmem_adapter #(.RespLatency(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req), .data_gnt_o(c_gnt),
    .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(c_rv), .data_rdata_o(c_rd),
    .data_err_o(c_err), .mem_req_o(c_mreq),
    .mem_gnt_i(mgnt), .mem_we_o(c_mwe),
    .mem_addr_o(c_ma), .mem_wmask_o(c_wm),
    .mem_wdata_o(c_wd), .mem_rdata_i(mrdata),
    .err_addr_o(c_ea), .err_clr_i(clr)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 1'b0;
      clr = 1'b0;
    end
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mg;
    logic [31:0] rd;
    logic        xg;
    logic        xmr;
    logic [11:0] xma;
    logic [31:0] xwm;
    logic        xrv;
    logic [31:0] xrd;
    logic        xer;
  } vec_t;

  vec_t vt [7];

  logic        eg [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
  logic        ev [8] = '{0, 0, 0, 1, 1, 0, 1, 0};
  logic [31:0] ed [8] = '{0, 0, 0, 32'hC0DE_0001,
                          32'hC0DE_0002, 0, 32'hC0DE_0004, 0};

  initial begin
    vt[0] = '{1, 0, BASE + 32'h8, 4'hF, 32'h0, 1,
              32'hDEAD_BEEF, 1, 1, 12'd2, 32'hFFFF_FFFF,
              1, 32'hDEAD_BEEF, 0};
    vt[1] = '{1, 1, BASE + 32'h10, 4'b0110, 32'h1122_3344, 1,
              32'hAAAA_5555, 1, 1, 12'd4, 32'h00FF_FF00,
              1, 32'h0, 0};
    vt[2] = '{1, 0, BASE + 32'hC, 4'hF, 32'h0, 0,
              32'h1234_5678, 0, 1, 12'd3, 32'hFFFF_FFFF,
              0, 32'h0, 0};
    vt[3] = '{0, 0, BASE + 32'h14, 4'hF, 32'h0, 1,
              32'h1234_5678, 0, 0, 12'd5, 32'hFFFF_FFFF,
              0, 32'h0, 0};
    vt[4] = '{1, 0, BASE + 32'h3FFC, 4'hF, 32'h0, 1,
              32'h0BAD_F00D, 1, 1, 12'd4095, 32'hFFFF_FFFF,
              1, 32'h0BAD_F00D, 0};
    vt[5] = '{1, 1, BASE + 32'h20, 4'b1001, 32'hCAFE_0001, 1,
              32'h7777_7777, 1, 1, 12'd8, 32'hFF00_00FF,
              1, 32'h0, 0};
`ifdef IBEX_DMEM_RANGE_CHK_EN
    vt[6] = '{1, 0, 32'h0000_0004, 4'hF, 32'h0, 0,
              32'h5555_AAAA, 1, 0, 12'd1, 32'hFFFF_FFFF,
              1, 32'h0, 1};
`else
    vt[6] = '{1, 0, 32'h0000_0004, 4'hF, 32'h0, 1,
              32'h5555_AAAA, 1, 1, 12'd1, 32'hFFFF_FFFF,
              1, 32'h5555_AAAA, 0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_rv", {31'b0, a_rv}, 0);
    chk("rst_b_rv", {31'b0, b_rv}, 0);
    rst_n = 1'b1;
    #2;
    chk("rst_a_gnt", {31'b0, a_gnt}, 0);
    chk("rst_a_mreq", {31'b0, a_mreq}, 0);
    chk("rst_a_err", {31'b0, a_err}, 0);
    chk("rst_a_ea", a_ea, 0);
    chk("rst_c_rv", {31'b0, c_rv}, 0);

    // Single transactions on latency-1 instance
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req = vt[i].req;
      we = vt[i].we;
      addr = vt[i].addr;
      be = vt[i].be;
      wdata = vt[i].wd;
      mgnt = vt[i].mg;
      #2;
      chk($sformatf("v%0d_gnt", i), {31'b0, a_gnt}, {31'b0, vt[i].xg});
      chk($sformatf("v%0d_mreq", i), {31'b0, a_mreq},
          {31'b0, vt[i].xmr});
      if (vt[i].xmr) begin
        chk($sformatf("v%0d_maddr", i), {20'b0, a_ma},
            {20'b0, vt[i].xma});
        chk($sformatf("v%0d_wmask", i), a_wm, vt[i].xwm);
        chk($sformatf("v%0d_mwe", i), {31'b0, a_mwe},
            {31'b0, vt[i].we});
        chk($sformatf("v%0d_wdata", i), a_wd, vt[i].wd);
      end
      @(negedge clk);
      req = 1'b0;
      mrdata = vt[i].rd;
      #2;
      chk($sformatf("v%0d_rv", i), {31'b0, a_rv}, {31'b0, vt[i].xrv});
      chk($sformatf("v%0d_err", i), {31'b0, a_err},
          {31'b0, vt[i].xer});
      if (vt[i].xrv) begin
        chk($sformatf("v%0d_rdata", i), a_rd, vt[i].xrd);
      end
    end

    // Error address capture, clear, and load-over-clear
    @(negedge clk);
    #2;
`ifdef IBEX_DMEM_RANGE_CHK_EN
    chk("ea_load", a_ea, 32'h4);
`else
    chk("ea_load", a_ea, 32'h0);
`endif
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #2;
    chk("ea_clr", a_ea, 32'h0);
    req = 1'b1;
    we = 1'b0;
    addr = 32'h0000_0008;
    mgnt = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    req = 1'b0;
    clr = 1'b0;
    #2;
`ifdef IBEX_DMEM_RANGE_CHK_EN
    chk("ea_win", a_ea, 32'h8);
    chk("ea_win_err", {31'b0, a_err}, 1);
`else
    chk("ea_win", a_ea, 32'h0);
    chk("ea_win_err", {31'b0, a_err}, 0);
`endif
    clr = 1'b1;
    idle(6);

    // Outstanding limit with latency 3
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req = (c < 4);
      we = 1'b0;
      be = 4'hF;
      addr = BASE + 32'h20;
      mgnt = 1'b1;
      mrdata = 32'hC0DE_0000 + c;
      #2;
      chk($sformatf("lim_c%0d_gnt", c), {31'b0, b_gnt}, {31'b0, eg[c]});
      chk($sformatf("lim_c%0d_mreq", c), {31'b0, b_mreq},
          {31'b0, eg[c]});
      chk($sformatf("lim_c%0d_rv", c), {31'b0, b_rv}, {31'b0, ev[c]});
      if (ev[c]) begin
        chk($sformatf("lim_c%0d_rd", c), b_rd, ed[c]);
      end
    end
    idle(6);

    // SRAM arbiter stall
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req = 1'b1;
      addr = BASE + 32'h40;
      mgnt = 1'b0;
      #2;
      chk($sformatf("stl_c%0d_gnt", c), {31'b0, a_gnt}, 0);
      chk($sformatf("stl_c%0d_mreq", c), {31'b0, a_mreq}, 1);
      chk($sformatf("stl_c%0d_rv", c), {31'b0, a_rv}, 0);
    end
    @(negedge clk);
    mgnt = 1'b1;
    #2;
    chk("stl_gnt", {31'b0, a_gnt}, 1);
    @(negedge clk);
    req = 1'b0;
    mrdata = 32'h5A5A_0001;
    #2;
    chk("stl_rv", {31'b0, a_rv}, 1);
    chk("stl_rd", a_rd, 32'h5A5A_0001);
    @(negedge clk);
    #2;
    chk("stl_rv_once", {31'b0, a_rv}, 0);
    idle(4);

    // Reset with a latency-2 response in flight
    @(negedge clk);
    req = 1'b1;
    addr = BASE + 32'h44;
    mgnt = 1'b1;
    #2;
    chk("mrst_gnt", {31'b0, c_gnt}, 1);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_rv_in", {31'b0, c_rv}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("mrst_c%0d_rv", c), {31'b0, c_rv}, 0);
      @(negedge clk);
    end

    // Counter cleared: two back-to-back grants, then two responses
    for (int c = 0; c < 5; c++) begin
      req = (c < 2);
      addr = BASE + 32'h48;
      mgnt = 1'b1;
      mrdata = 32'hBEEF_0000 + c;
      #2;
      if (c < 2) begin
        chk($sformatf("b2b_c%0d_gnt", c), {31'b0, c_gnt}, 1);
      end
      chk($sformatf("b2b_c%0d_rv", c), {31'b0, c_rv},
          {31'b0, (c == 2 || c == 3)});
      if (c == 2 || c == 3) begin
        chk($sformatf("b2b_c%0d_rd", c), c_rd, 32'hBEEF_0000 + c - 1);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
